// File: rtl/phy_rx_deframer_pkg.sv
// Shared types and constants for the receive PHY deframer.
// CRC constants are consumed only when RECV_FCS_CHECK_EN is defined.
package phy_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_DROP
  } rx_state_e;

  localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam int ST_ALIGN_BIT = 0;
  localparam int ST_LEN_BIT   = 1;
  localparam int ST_FCS_BIT   = 2;

  // The CRC runs LSB-first, so the poly and residue are held bit-reversed.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/phy_rx_deframer_if.sv
// PHY-side nibble inputs plus byte/frame outputs of the deframer.
interface phy_rx_deframer_if;
    logic        phy_rx_dv;
    logic        phy_rx_er;
    logic [3:0]  phy_rx_data;
    logic [7:0]  rec_data;
    logic        rec_data_valid;
    logic [23:0] rec_ctrl;
    logic        rec_frame_valid;
    logic [2:0]  rec_status;

    modport master (
        output phy_rx_dv, phy_rx_er, phy_rx_data,
        input  rec_data, rec_data_valid, rec_ctrl, rec_frame_valid, rec_status
    );

    modport slave (
        input  phy_rx_dv, phy_rx_er, phy_rx_data,
        output rec_data, rec_data_valid, rec_ctrl, rec_frame_valid, rec_status
    );
endinterface

// File: rtl/phy_rx_deframer_crc32_byte_update.sv
// Combinational reflected CRC-32 step: next register value after one byte, LSB first.
module crc32_byte_update
    import phy_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_o[0] ^ byte_i[i]) crc_o = (crc_o >> 1) ^ POLY_R;
            else                      crc_o = crc_o >> 1;
        end
    end
endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: strips preamble/SFD, assembles bytes low nibble first, reports frame end.
// Optional FCS check under RECV_FCS_CHECK_EN.
module phy_rx_deframer
    import phy_rx_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int PRE_MIN = 2
)(
    input logic             clk_phy,
    input logic             reset,
    phy_rx_deframer_if.slave rx
);
    localparam logic [12:0] MAX_L = 13'(MAX_LEN);
    localparam logic [12:0] MIN_L = 13'(MIN_LEN);
    localparam logic [3:0]  PRE_M = 4'(PRE_MIN);

    rx_state_e   state_q, state_d;
    logic [3:0]  pre_q, pre_d;
    logic [3:0]  nib_q, nib_d;
    logic [12:0] len_q, len_d;
    logic        align_q, align_d;
    logic [7:0]  data_q, data_d;
    logic        dvld_q, dvld_d;
    logic        fvld_q, fvld_d;
    logic [23:0] ctrl_q, ctrl_d;
    logic [2:0]  stat_q, stat_d;
    logic        fcs_bad;
    logic [7:0]  byte_w;

    assign byte_w = {rx.phy_rx_data, nib_q};

`ifdef RECV_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_nxt;

    crc32_byte_update u_crc (
        .crc_i  (crc_q),
        .byte_i (byte_w),
        .crc_o  (crc_nxt)
    );

    assign fcs_bad = (bitrev32(crc_q) != CRC_RESIDUE);

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) crc_q <= CRC_INIT;
        else        crc_q <= crc_d;
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        nib_d   = nib_q;
        len_d   = len_q;
        align_d = align_q;
        data_d  = data_q;
        dvld_d  = 1'b0;
        fvld_d  = 1'b0;
        ctrl_d  = ctrl_q;
        stat_d  = stat_q;
`ifdef RECV_FCS_CHECK_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx.phy_rx_dv) begin
                    if (rx.phy_rx_data == PRE_NIBBLE) begin
                        state_d = ST_PREAMBLE;
                        pre_d   = 4'd1;
                        align_d = rx.phy_rx_er;
                        len_d   = '0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx.phy_rx_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    if (rx.phy_rx_er) align_d = 1'b1;
                    if (rx.phy_rx_data == PRE_NIBBLE) begin
                        if (pre_q != 4'hF) pre_d = pre_q + 4'd1;
                    end else if (rx.phy_rx_data == SFD_NIBBLE && pre_q >= PRE_M) begin
                        state_d = ST_DATA_LO;
                        len_d   = '0;
`ifdef RECV_FCS_CHECK_EN
                        crc_d   = CRC_INIT;
`endif
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DATA_LO, ST_DATA_HI: begin
                if (!rx.phy_rx_dv) begin
                    // Frame end; a dangling high-nibble slot means an odd nibble count.
                    state_d               = ST_IDLE;
                    fvld_d                = 1'b1;
                    ctrl_d                = {len_q[11:0], len_q[11:0]};
                    stat_d[ST_ALIGN_BIT]  = align_q | (state_q == ST_DATA_HI);
                    stat_d[ST_LEN_BIT]    = (len_q < MIN_L) || (len_q > MAX_L);
                    stat_d[ST_FCS_BIT]    = fcs_bad;
                end else begin
                    if (rx.phy_rx_er) align_d = 1'b1;
                    if (state_q == ST_DATA_LO) begin
                        nib_d   = rx.phy_rx_data;
                        state_d = ST_DATA_HI;
                    end else begin
                        state_d = ST_DATA_LO;
                        if (len_q < MAX_L) begin
                            data_d = byte_w;
                            dvld_d = 1'b1;
                            len_d  = len_q + 13'd1;
`ifdef RECV_FCS_CHECK_EN
                            crc_d  = crc_nxt;
`endif
                        end else begin
                            len_d  = MAX_L + 13'd1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!rx.phy_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            nib_q   <= '0;
            len_q   <= '0;
            align_q <= 1'b0;
            data_q  <= '0;
            dvld_q  <= 1'b0;
            fvld_q  <= 1'b0;
            ctrl_q  <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            nib_q   <= nib_d;
            len_q   <= len_d;
            align_q <= align_d;
            data_q  <= data_d;
            dvld_q  <= dvld_d;
            fvld_q  <= fvld_d;
            ctrl_q  <= ctrl_d;
            stat_q  <= stat_d;
        end
    end

    assign rx.rec_data        = data_q;
    assign rx.rec_data_valid  = dvld_q;
    assign rx.rec_ctrl        = ctrl_q;
    assign rx.rec_frame_valid = fvld_q;
    assign rx.rec_status      = stat_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Directed bench for phy_rx_deframer; FCS cases compile in with RECV_FCS_CHECK_EN.
module tb_phy_rx_deframer;
    logic clk_phy = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_phy = ~clk_phy;

    phy_rx_deframer_if bus ();

    phy_rx_deframer #(.MAX_LEN(1518), .MIN_LEN(64), .PRE_MIN(2)) dut (
        .clk_phy (clk_phy),
        .reset   (reset),
        .rx      (bus.slave)
    );

`ifdef RECV_FCS_CHECK_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    int nchk = 0;
    int nerr = 0;
    logic [7:0]  fb [0:1599];
    logic [7:0]  rx_q [$];
    logic [23:0] fctrl_q [$];
    logic [2:0]  fstat_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk_phy) begin
        if (bus.rec_data_valid)  rx_q.push_back(bus.rec_data);
        if (bus.rec_frame_valid) begin
            fctrl_q.push_back(bus.rec_ctrl);
            fstat_q.push_back(bus.rec_status);
        end
        if (bus.rec_data_valid && bus.rec_frame_valid) chk("strobe_overlap", 1, 0);
    end

    task automatic nib(input logic dv, input logic [3:0] d, input logic er);
        @(posedge clk_phy); #1;
        bus.phy_rx_dv   = dv;
        bus.phy_rx_data = d;
        bus.phy_rx_er   = er;
    endtask

    task automatic idle(input int n);
        repeat (n) nib(1'b0, 4'h0, 1'b0);
    endtask

    // Preamble, SFD, bytes low nibble first, optional stray nibble, one dv-low cycle.
    task automatic send_frame(input int npre, input int nbytes, input bit odd, input bit er_mid);
        for (int i = 0; i < npre; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            nib(1'b1, fb[i][3:0], 1'b0);
            nib(1'b1, fb[i][7:4], er_mid && (i == nbytes / 2));
        end
        if (odd) nib(1'b1, 4'hA, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        fctrl_q.delete();
        fstat_q.delete();
    endtask

    task automatic check_frames(input string tag, input int nbytes, input int per_frame,
                                input int nfr, input logic [23:0] ctrl, input logic [2:0] stat);
        int bad;
        bad = 0;
        chk({tag, "_nbytes"}, rx_q.size(), nbytes);
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] !== fb[i % per_frame]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        chk({tag, "_nframes"}, fctrl_q.size(), nfr);
        for (int f = 0; f < fctrl_q.size(); f++) begin
            chk({tag, "_ctrl"}, fctrl_q[f], ctrl);
            chk({tag, "_status"}, fstat_q[f], stat);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    initial begin
        logic [31:0] crc;
        bus.phy_rx_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 4'h0;
        for (int i = 0; i < 1600; i++) fb[i] = 8'(i);

        repeat (3) @(posedge clk_phy);
        @(negedge clk_phy);
        chk("rst_data",  bus.rec_data, 0);
        chk("rst_dvld",  bus.rec_data_valid, 0);
        chk("rst_ctrl",  bus.rec_ctrl, 0);
        chk("rst_fvld",  bus.rec_frame_valid, 0);
        chk("rst_stat",  bus.rec_status, 0);
        @(posedge clk_phy); #2 reset = 1'b1;
        idle(2);

        clear_mon(); send_frame(15, 64, 0, 0); idle(4);
        check_frames("f64", 64, 64, 1, 24'h040040, {FCS_ON, 2'b00});

        clear_mon(); send_frame(15, 512, 0, 0); send_frame(7, 512, 0, 0); idle(4);
        check_frames("b2b512", 1024, 512, 2, 24'h200200, {FCS_ON, 2'b00});

        clear_mon(); send_frame(15, 64, 1, 0); idle(4);
        check_frames("odd", 64, 64, 1, 24'h040040, {FCS_ON, 2'b01});

        clear_mon(); send_frame(2, 10, 0, 0); idle(4);
        check_frames("short10", 10, 10, 1, 24'h00A00A, {FCS_ON, 2'b10});

        clear_mon(); send_frame(15, 1600, 0, 0); idle(4);
        check_frames("long1600", 1518, 1600, 1, 24'h5EF5EF, {FCS_ON, 2'b10});

        clear_mon(); send_frame(5, 0, 0, 0); idle(4);
        check_frames("zero", 0, 1, 1, 24'h000000, {FCS_ON, 2'b10});

        clear_mon(); send_frame(8, 64, 0, 1); idle(4);
        check_frames("rx_er", 64, 64, 1, 24'h040040, {FCS_ON, 2'b01});

        // 0x5,0x3 preamble, then a lone 0x5 before SFD: both must drop silently.
        clear_mon();
        nib(1, 4'h5, 0); nib(1, 4'h3, 0);
        for (int i = 0; i < 6; i++) nib(1, 4'hD, 0);
        idle(1);
        nib(1, 4'h5, 0); nib(1, 4'hD, 0);
        for (int i = 0; i < 6; i++) nib(1, 4'h1, 0);
        idle(4);
        chk("drop_nbytes", rx_q.size(), 0);
        chk("drop_nframes", fctrl_q.size(), 0);

        // Reset mid-frame while ctrl still holds the previous frame's word.
        for (int i = 0; i < 15; i++) nib(1, 4'h5, 0);
        nib(1, 4'hD, 0);
        for (int i = 0; i < 5; i++) begin nib(1, fb[i][3:0], 0); nib(1, fb[i][7:4], 0); end
        #2 reset = 1'b0;
        #1;
        chk("midrst_data", bus.rec_data, 0);
        chk("midrst_dvld", bus.rec_data_valid, 0);
        chk("midrst_ctrl", bus.rec_ctrl, 0);
        chk("midrst_fvld", bus.rec_frame_valid, 0);
        chk("midrst_stat", bus.rec_status, 0);
        idle(2);
        clear_mon();
        #2 reset = 1'b1;
        idle(4);
        chk("postrst_nbytes", rx_q.size(), 0);
        chk("postrst_nframes", fctrl_q.size(), 0);
        clear_mon(); send_frame(15, 64, 0, 0); idle(4);
        check_frames("postrst64", 64, 64, 1, 24'h040040, {FCS_ON, 2'b00});

`ifdef RECV_FCS_CHECK_EN
        // 60 payload bytes then FCS = ~crc, transmitted least significant byte first.
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) crc = crc_upd(crc, fb[i]);
        crc = ~crc;
        for (int k = 0; k < 4; k++) fb[60+k] = crc[8*k +: 8];
        clear_mon(); send_frame(15, 64, 0, 0); idle(4);
        check_frames("fcs_good", 64, 64, 1, 24'h040040, 3'b000);
        fb[17] = fb[17] ^ 8'h04;
        clear_mon(); send_frame(15, 64, 0, 0); idle(4);
        check_frames("fcs_bad", 64, 64, 1, 24'h040040, 3'b100);
`else
        crc = 32'h0;
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
